fifo_axi_wr_sched: RTL

- Scheduler that drains the byte FIFO on the UART-to-DDR path and issues AXI4 INCR write bursts to DDR.
- Tracks FIFO occupancy by snooping the FIFO's write strobe, since the FIFO exposes only full/empty.
- Sequences FIFO reads and runs the AW/W/B handshakes.
- Flushes partial bursts after an idle timeout.
- Advances the DDR write address through a circular region.

---
 rtl/fifo_axi_wr_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fifo_axi_wr_sched.sv
// Drains the UART-to-DDR byte FIFO into AXI4 INCR write bursts over a circular DDR region.
// FIFO occupancy is tracked by snooping the FIFO write strobe; partial bursts flush after an idle timeout.
module fifo_axi_wr_sched #(
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    FIFO_DEPTH   = 16,
   parameter int                    BURST_LEN    = 4,
   parameter int                    TIMEOUT      = 255,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    REGION_BYTES = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_w_en,
   input  logic                  fifo_full,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_r_en,
   output logic [ADDR_WIDTH-1:0] m_awaddr,
   output logic [7:0]            m_awlen,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic                  m_wlast,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   output logic                  busy,
   output logic                  err,
   output logic [15:0]           burst_cnt
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [LVL_W-1:0]      BURST_L     = LVL_W'(BURST_LEN);
   localparam logic [LVL_W-1:0]      ONE_L       = LVL_W'(1);
   localparam logic [TMR_W-1:0]      TIMEOUT_T   = TMR_W'(TIMEOUT);
   localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES  = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] REGION_MASK = ADDR_WIDTH'(REGION_BYTES - 1);

   typedef enum logic [2:0] {S_IDLE, S_AW, S_RD, S_LD, S_W, S_B} state_e;

   state_e                  state_q, state_d;
   logic [LVL_W-1:0]        level_q, level_d;
   logic [TMR_W-1:0]        timer_q, timer_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LVL_W-1:0]        len_q, len_d;
   logic [LVL_W-1:0]        beat_q, beat_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    wlast_q, wlast_d;
   logic                    err_q, err_d;
   logic [15:0]             burst_cnt_q, burst_cnt_d;
   logic                    wr_acc;
   logic [ADDR_WIDTH-1:0]   region_offs;

   assign wr_acc = fifo_w_en && !fifo_full;
   // Modulo arithmetic on the offset keeps the address inside the power-of-2 region.
   assign region_offs = (addr_q - BASE_ADDR + ADDR_WIDTH'(len_q) * BEAT_BYTES) & REGION_MASK;

   always_comb begin
      // NOTE: every variable gets a default before the case so no latch is inferred.
      state_d     = state_q;
      len_d       = len_q;
      beat_d      = beat_q;
      wdata_d     = wdata_q;
      wlast_d     = wlast_q;
      err_d       = err_q;
      burst_cnt_d = burst_cnt_q;
      addr_d      = addr_q;
      fifo_r_en   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (level_q >= BURST_L) begin
               len_d   = BURST_L;
               state_d = S_AW;
            end else if (level_q != '0 && timer_q == TIMEOUT_T) begin
               len_d   = level_q;
               state_d = S_AW;
            end
         end
         S_AW: if (m_awready) state_d = S_RD;
         S_RD: begin
            if (!fifo_empty) begin
               fifo_r_en = 1'b1;
               state_d   = S_LD;
            end
         end
         S_LD: begin
            wdata_d = fifo_dout;
            wlast_d = (beat_q == len_q - ONE_L);
            state_d = S_W;
         end
         S_W: begin
            if (m_wready) begin
               wlast_d = 1'b0;
               if (wlast_q) begin
                  state_d = S_B;
               end else begin
                  beat_d  = beat_q + ONE_L;
                  state_d = S_RD;
               end
            end
         end
         S_B: begin
            if (m_bvalid) begin
               err_d       = err_q | (m_bresp != 2'b00);
               burst_cnt_d = burst_cnt_q + 16'd1;
               addr_d      = BASE_ADDR + region_offs;
               beat_d      = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      level_d = level_q;
      if (wr_acc && !fifo_r_en)      level_d = level_q + ONE_L;
      else if (!wr_acc && fifo_r_en) level_d = level_q - ONE_L;

      timer_d = '0;
      if (state_q == S_IDLE && state_d == S_IDLE && !wr_acc && level_q != '0) begin
         if (level_q < BURST_L && timer_q != TIMEOUT_T) timer_d = timer_q + TMR_W'(1);
         else                                           timer_d = timer_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         level_q     <= '0;
         timer_q     <= '0;
         addr_q      <= BASE_ADDR;
         len_q       <= '0;
         beat_q      <= '0;
         wdata_q     <= '0;
         wlast_q     <= 1'b0;
         err_q       <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         timer_q     <= timer_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         wdata_q     <= wdata_d;
         wlast_q     <= wlast_d;
         err_q       <= err_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign m_awvalid = (state_q == S_AW);
   assign m_awaddr  = m_awvalid ? addr_q : '0;
   assign m_awlen   = m_awvalid ? 8'(len_q - ONE_L) : 8'd0;
   assign m_wvalid  = (state_q == S_W);
   assign m_wdata   = wdata_q;
   assign m_wlast   = wlast_q;
   assign m_bready  = (state_q == S_B);
   assign busy      = (state_q != S_IDLE);
   assign err       = err_q;
   assign burst_cnt = burst_cnt_q;

endmodule
